axon_decoder: RTL and testbench
===============================

# axon_decoder

- Consumes spike packets from the core's input packet FIFO and schedules each packet as one bit in a per-tick axon slot bank.
- On every `tick` it drains the FIFO, then delivers the current tick's axon spike vector to the neuron stage, clears that slot and advances the slot pointer.
- Position in the core: FIFO read side → neuron block.

## Interface
Parameters:
- NUM_AXONS, 256, axon count; AXON_BITS = $clog2(NUM_AXONS)
- NUM_TICKS, 16, scheduling horizon in ticks, power of two; TICK_BITS = $clog2(NUM_TICKS)
- PACKET_WIDTH, TICK_BITS+AXON_BITS (12), FIFO data width

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock, reset is synchronous and active-high
- fifo_empty  in  1  FIFO empty flag, combinational from FIFO pointers
- fifo_r_en  out  1  FIFO read request
- fifo_data  in  PACKET_WIDTH  FIFO read data, qualified by fifo_valid
- fifo_valid  in  1  FIFO read data valid, one cycle after an accepted read
- tick  in  1  single-cycle tick pulse
- axon_spikes  out  NUM_AXONS  spike vector for the delivered tick
- axon_spikes_valid  out  1  one-cycle pulse qualifying axon_spikes
- tick_overrun  out  1  sticky: tick arrived while not in RUN
- pkt_count  out  16  scheduled-packet counter (see Configuration)

## Operation
Packet format:
- fifo_data[AXON_BITS-1:0] is the axon index.
- fifo_data[PACKET_WIDTH-1:AXON_BITS] is the tick offset d.

Scheduling:
- Target slot = (cur_ptr + d) mod NUM_TICKS. Pointer arithmetic is TICK_BITS wide and wraps naturally.
- d = 0 means the packet is delivered at the next tick.
- A write sets bank[slot][axon] (OR). Duplicate packets are idempotent.

FSM states: RUN, DRAIN, DELIVER.
- RUN:
  - fifo_r_en = !fifo_empty.
  - tick → DRAIN.
- DRAIN:
  - fifo_r_en = !fifo_empty.
  - rd_out is the registered fifo_r_en, i.e. a read is still in flight.
  - Exit to DELIVER when fifo_empty && !rd_out.
  - Upstream must quiesce; packets entering the FIFO during DRAIN are scheduled under the pre-advance pointer.
- DELIVER (exactly 1 cycle):
  - fifo_r_en = 0.
  - Register axon_spikes <= bank[cur_ptr], then clear bank[cur_ptr] and increment cur_ptr.
  - Next state RUN.
- fifo_valid is honoured in every state. By construction no valid arrives during DELIVER.
- tick in DRAIN or DELIVER: the tick is ignored and tick_overrun is set. Only rst clears tick_overrun.

Reset values:
- state = RUN; cur_ptr = 0; all bank bits = 0.
- axon_spikes = 0, axon_spikes_valid = 0, fifo_r_en = 0, tick_overrun = 0, pkt_count = 0.
- rst mid-DRAIN or mid-DELIVER aborts the operation, discards the bank contents and produces no valid pulse.

## Timing
- Read pipeline: fifo_r_en high in cycle n → fifo_valid/fifo_data in n+1 → bank bit set at the n+2 edge.
- Throughput: one packet per cycle.
- Minimum tick latency, with FIFO empty at the tick:
  - tick sampled at T.
  - DRAIN in T+1.
  - DELIVER in T+2.
  - axon_spikes_valid high in T+3.
- Each FIFO entry pending at the tick adds 1 cycle.
- axon_spikes holds its value until the next delivery. axon_spikes_valid is high for exactly 1 cycle per accepted tick.
- A packet with slot == cur_ptr whose fifo_valid arrives before DRAIN exits is included in that delivery.

## Configuration
AXON_DECODER_STATS_EN:
- Defined:
  - pkt_count increments on every fifo_valid.
  - It saturates at 16'hFFFF.
  - It is cleared only by rst.
- Undefined: pkt_count is tied to 0 and no counter logic is built. The port list is identical in both builds.

## Structure
Shared package axon_decoder_pkg holds:
- NUM_AXONS, NUM_TICKS, AXON_BITS, TICK_BITS, PACKET_WIDTH defaults.
- The state encoding: RUN = 0, DRAIN = 1, DELIVER = 2.

Sub-module axon_slot_bank (NUM_TICKS × NUM_AXONS flops):
- Set port: slot, axon, en.
- Read-and-clear port: slot, en.
- Read-and-clear of the slot being set in the same cycle is never exercised by the FSM, so no bypass is needed.

The FSM, cur_ptr and the counter live in the top-level block.

## Test plan
1. Reset, then tick with FIFO empty → fifo_r_en stays 0; axon_spikes_valid at T+3 with axon_spikes = 0; cur_ptr = 1.
2. Push packets {d=0, axon=5} and {d=0, axon=200}, then tick → delivered vector has only bits 5 and 200 set; the next tick delivers all zeros.
3. Push {d=3, axon=7}, then 4 ticks → bit 7 appears only on the 4th delivery. Repeat with cur_ptr = 14 and d = 3 → bit appears on the 4th tick after wrapping (slot 1).
4. Push 8 packets back-to-back, then tick 1 cycle after the last push → 8 consecutive fifo_r_en; all 8 bits delivered; valid at T+11 or earlier per the latency rule.
5. Assert tick during DRAIN → tick_overrun = 1 and stays high; exactly one delivery occurs. Then rst → tick_overrun = 0, the bank is cleared, and the next tick delivers zeros.
6. With AXON_DECODER_STATS_EN defined, push 70000 packets → pkt_count = 16'hFFFF. Without the macro, pkt_count = 0 throughout.

Source files
------------

// File: rtl/axon_decoder_pkg.sv
// Shared defaults and FSM encoding for the axon decoder.
package axon_decoder_pkg;

    localparam int NUM_AXONS       = 256;
    localparam int NUM_TICKS       = 16;
    localparam int AXON_BITS       = $clog2(NUM_AXONS);
    localparam int TICK_BITS       = $clog2(NUM_TICKS);
    localparam int PACKET_WIDTH    = TICK_BITS + AXON_BITS;
    localparam int PKT_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DELIVER = 2'd2
    } dec_state_e;

endpackage

// File: rtl/axon_slot_bank.sv
// Per-tick axon slot bank: one bit-set port and one read-and-clear port.
module axon_slot_bank #(
    parameter  int NUM_AXONS = axon_decoder_pkg::NUM_AXONS,
    parameter  int NUM_TICKS = axon_decoder_pkg::NUM_TICKS,
    localparam int AB        = $clog2(NUM_AXONS),
    localparam int TB        = $clog2(NUM_TICKS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [TB-1:0]        set_slot,
    input  logic [AB-1:0]        set_axon,
    input  logic                 rc_en,
    input  logic [TB-1:0]        rc_slot,
    output logic [NUM_AXONS-1:0] rd_data
);

    logic [NUM_AXONS-1:0] rows [NUM_TICKS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TICKS; gi++) begin : g_slot
            logic [NUM_AXONS-1:0] row_q;
            logic [NUM_AXONS-1:0] row_d;

            // Clear is applied before set so a same-cycle set is never lost.
            always_comb begin
                row_d = row_q;
                if (rc_en && (rc_slot == TB'(gi))) begin
                    row_d = '0;
                end
                if (set_en && (set_slot == TB'(gi))) begin
                    row_d[set_axon] = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    row_q <= '0;
                end else begin
                    row_q <= row_d;
                end
            end

            assign rows[gi] = row_q;
        end
    endgenerate

    assign rd_data = rows[rc_slot];

endmodule

// File: rtl/axon_decoder.sv
// Spike packet scheduler: drains the input FIFO into per-tick axon slots and
// delivers one slot per tick. Optional packet counter: AXON_DECODER_STATS_EN.
module axon_decoder
    import axon_decoder_pkg::*;
#(
    parameter  int NUM_AXONS    = axon_decoder_pkg::NUM_AXONS,
    parameter  int NUM_TICKS    = axon_decoder_pkg::NUM_TICKS,
    parameter  int PACKET_WIDTH = $clog2(NUM_TICKS) + $clog2(NUM_AXONS),
    localparam int AB           = $clog2(NUM_AXONS),
    localparam int TB           = $clog2(NUM_TICKS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fifo_empty,
    output logic                    fifo_r_en,
    input  logic [PACKET_WIDTH-1:0] fifo_data,
    input  logic                    fifo_valid,
    input  logic                    tick,
    output logic [NUM_AXONS-1:0]    axon_spikes,
    output logic                    axon_spikes_valid,
    output logic                    tick_overrun,
    output logic [15:0]             pkt_count
);

    dec_state_e           state_q, state_d;
    logic [TB-1:0]        cur_ptr_q, cur_ptr_d;
    logic                 rd_out_q;
    logic [NUM_AXONS-1:0] axon_spikes_q, axon_spikes_d;
    logic                 spikes_valid_q, spikes_valid_d;
    logic                 tick_overrun_q, tick_overrun_d;
    logic                 rd_en;
    logic                 deliver;
    logic [AB-1:0]        pkt_axon;
    logic [TB-1:0]        pkt_offset;
    logic [TB-1:0]        set_slot;
    logic [NUM_AXONS-1:0] slot_rd_data;

    assign pkt_axon   = fifo_data[AB-1:0];
    assign pkt_offset = fifo_data[PACKET_WIDTH-1:AB];
    assign set_slot   = cur_ptr_q + pkt_offset;

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        deliver = 1'b0;
        case (state_q)
            RUN: begin
                rd_en = !fifo_empty;
                if (tick) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                rd_en = !fifo_empty;
                // Leave only once no read is still on its way back from the FIFO.
                if (fifo_empty && !rd_out_q) begin
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                deliver = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        cur_ptr_d      = deliver ? cur_ptr_q + TB'(1) : cur_ptr_q;
        axon_spikes_d  = deliver ? slot_rd_data : axon_spikes_q;
        spikes_valid_d = deliver;
        tick_overrun_d = tick_overrun_q | (tick && (state_q != RUN));
    end

    assign fifo_r_en = rd_en && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            cur_ptr_q      <= '0;
            rd_out_q       <= 1'b0;
            axon_spikes_q  <= '0;
            spikes_valid_q <= 1'b0;
            tick_overrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_ptr_q      <= cur_ptr_d;
            rd_out_q       <= fifo_r_en;
            axon_spikes_q  <= axon_spikes_d;
            spikes_valid_q <= spikes_valid_d;
            tick_overrun_q <= tick_overrun_d;
        end
    end

    axon_slot_bank #(
        .NUM_AXONS (NUM_AXONS),
        .NUM_TICKS (NUM_TICKS)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .set_en   (fifo_valid),
        .set_slot (set_slot),
        .set_axon (pkt_axon),
        .rc_en    (deliver),
        .rc_slot  (cur_ptr_q),
        .rd_data  (slot_rd_data)
    );

    assign axon_spikes       = axon_spikes_q;
    assign axon_spikes_valid = spikes_valid_q;
    assign tick_overrun      = tick_overrun_q;

`ifdef AXON_DECODER_STATS_EN
    logic [PKT_COUNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

    always_comb begin
        pkt_count_d = pkt_count_q;
        if (fifo_valid && (pkt_count_q != 16'hFFFF)) begin
            pkt_count_d = pkt_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_count_q <= '0;
        end else begin
            pkt_count_q <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_axon_decoder.sv
// Directed bench for axon_decoder with a small behavioural FIFO on the read side.
module tb_axon_decoder;

    logic         clk = 1'b0;
    logic         rst;
    logic         fifo_empty;
    logic         fifo_r_en;
    logic [11:0]  fifo_data;
    logic         fifo_valid;
    logic         tick;
    logic [255:0] axon_spikes;
    logic         axon_spikes_valid;
    logic         tick_overrun;
    logic [15:0]  pkt_count;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ptr = 0;
    int rd_count = 0;

    logic [11:0] fmem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;

    axon_decoder dut (
        .clk               (clk),
        .rst               (rst),
        .fifo_empty        (fifo_empty),
        .fifo_r_en         (fifo_r_en),
        .fifo_data         (fifo_data),
        .fifo_valid        (fifo_valid),
        .tick              (tick),
        .axon_spikes       (axon_spikes),
        .axon_spikes_valid (axon_spikes_valid),
        .tick_overrun      (tick_overrun),
        .pkt_count         (pkt_count)
    );

    always #5 clk = ~clk;

    // Read-side FIFO model: data one cycle after an accepted read, flushed by rst.
    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= wr_ptr;
            fifo_valid <= 1'b0;
        end else if (fifo_r_en && (wr_ptr != rd_ptr)) begin
            fifo_data  <= fmem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
            fifo_valid <= 1'b1;
        end else begin
            fifo_valid <= 1'b0;
        end
        if (fifo_r_en) begin
            rd_count <= rd_count + 1;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: observed no finish by time limit, required self-termination");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [255:0] oh(input int a);
        logic [255:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    function automatic int exp_cnt(input int n);
`ifdef AXON_DECODER_STATS_EN
        return (n > 65535) ? 65535 : n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int d, input int axon);
        while ((wr_ptr - rd_ptr) >= 255) @(negedge clk);
        fmem[wr_ptr[7:0]] = {d[3:0], axon[7:0]};
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic count_valids(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (axon_spikes_valid) n++;
        end
    endtask

    // Pulse tick (called at a negedge), measure latency in cycles, check data and hold.
    task automatic do_tick(input string tag, input int exp_lat, input logic [255:0] exp_spikes);
        int lat;
        logic [255:0] sp;
        lat = 0;
        sp  = '0;
        tick = 1'b1;
        for (int i = 1; i <= exp_lat + 4; i++) begin
            @(negedge clk);
            tick = 1'b0;
            if (axon_spikes_valid) begin
                lat = i;
                sp  = axon_spikes;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_spk"}, sp, exp_spikes);
        @(negedge clk);
        check({tag, "_pulse"}, axon_spikes_valid, 1'b0);
        check({tag, "_hold"}, axon_spikes, exp_spikes);
        exp_ptr = (exp_ptr + 1) % 16;
    endtask

    initial begin
        int r0;
        int nv;
        int more;
        logic [255:0] acc;

        rst  = 1'b1;
        tick = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_r_en", fifo_r_en, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_spikes", axon_spikes, '0);
        check("rst_valid", axon_spikes_valid, 1'b0);
        check("rst_overrun", tick_overrun, 1'b0);
        check("rst_pkt", pkt_count, 16'd0);

        // 1: empty FIFO tick
        r0 = rd_count;
        do_tick("t1_empty", 3, '0);
        check("t1_no_reads", rd_count - r0, 0);

        // 2: two d=0 packets, then an empty follow-up delivery
        push(0, 5);
        push(0, 200);
        repeat (4) @(negedge clk);
        do_tick("t2_pair", 3, oh(5) | oh(200));
        do_tick("t2_next", 3, '0);
        check("t2_pkt", pkt_count, 16'(exp_cnt(2)));

        // 2b: three entries pending at the tick add three cycles
        push(0, 17);
        push(0, 18);
        push(0, 19);
        do_tick("t2b_pending", 6, oh(17) | oh(18) | oh(19));

        // 3: d=3 lands on the fourth delivery
        push(3, 7);
        repeat (4) @(negedge clk);
        do_tick("t3_a1", 3, '0);
        do_tick("t3_a2", 3, '0);
        do_tick("t3_a3", 3, '0);
        do_tick("t3_a4", 3, oh(7));
        while (exp_ptr != 14) do_tick("t3_adv", 3, '0);
        push(3, 7);
        repeat (4) @(negedge clk);
        do_tick("t3_w1", 3, '0);
        do_tick("t3_w2", 3, '0);
        do_tick("t3_w3", 3, '0);
        do_tick("t3_w4", 3, oh(7));
        check("t3_ptr_wrapped", exp_ptr, 2);

        // 4: eight back-to-back packets, tick one cycle after the last push
        r0  = rd_count;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            push(0, 30 + i * 10);
            acc = acc | oh(30 + i * 10);
            @(negedge clk);
        end
        do_tick("t4_burst", 3, acc);
        check("t4_reads", rd_count - r0, 8);
        check("t4_overrun", tick_overrun, 1'b0);

        // 5: tick held into DRAIN sets the sticky overrun, one delivery only
        nv   = 0;
        tick = 1'b1;
        @(negedge clk);
        if (axon_spikes_valid) nv++;
        @(negedge clk);
        tick = 1'b0;
        if (axon_spikes_valid) nv++;
        count_valids(8, more);
        check("t5_one_delivery", nv + more, 1);
        check("t5_overrun", tick_overrun, 1'b1);
        exp_ptr = (exp_ptr + 1) % 16;
        do_tick("t5_after", 3, '0);
        check("t5_sticky", tick_overrun, 1'b1);
        push((16 - exp_ptr) % 16, 77);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_ptr = 0;
        check("t5_rst_overrun", tick_overrun, 1'b0);
        check("t5_rst_spikes", axon_spikes, '0);
        do_tick("t5_cleared", 3, '0);

        // rst in the middle of DRAIN: no delivery, bank discarded
        push(0, 3);
        push(0, 4);
        push(0, 5);
        push(0, 6);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_valids(10, nv);
        check("t5_abort_no_valid", nv, 0);
        exp_ptr = 0;
        do_tick("t5_abort_zero", 3, '0);
        check("t5_abort_pkt", pkt_count, 16'd0);

        // 6: packet counter saturation / tied-off build
`ifdef AXON_DECODER_STATS_EN
        for (int i = 0; i < 70000; i++) begin
            push(0, i % 256);
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("t6_pkt_sat", pkt_count, 16'hFFFF);
`else
        for (int i = 0; i < 40; i++) begin
            push(0, i);
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        check("t6_pkt_zero", pkt_count, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
